// File: rtl/dram_seq_arb.sv
// Single-bank RU6 DRAM sequencer: CPU/video arbitration plus RAS-only refresh timer.
// Optional macro DRAM_SEQ_FAIR_EN selects round-robin video/CPU arbitration (default: video > CPU).
module dram_seq_arb #(
  parameter int T_RCD      = 2,
  parameter int T_CAS      = 2,
  parameter int T_RP       = 2,
  parameter int REF_PERIOD = 250
) (
  input  logic        pin_clk,
  input  logic        pin_rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_rdata,
  output logic [6:0]  ram_ma,
  output logic [7:0]  ram_di,
  input  logic [7:0]  ram_do,
  output logic        ram_ras_n,
  output logic        ram_cas_n,
  output logic        ram_we_n,
  output logic        ref_miss
);

  localparam int TW   = $clog2(REF_PERIOD);
  localparam int CMAX = (T_RCD > T_CAS) ? ((T_RCD > T_RP) ? T_RCD : T_RP)
                                        : ((T_CAS > T_RP) ? T_CAS : T_RP);
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [TW-1:0] TMR_LAST = TW'(REF_PERIOD - 1);
  localparam logic [CW-1:0] RCD_LAST = CW'(T_RCD - 1);
  localparam logic [CW-1:0] CAS_LAST = CW'(T_CAS - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'(T_RP - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_RAS, S_CAS, S_PRE} state_t;
  typedef enum logic [1:0] {K_REF, K_VID, K_CPU} kind_t;

  state_t         state;
  kind_t          kind;
  logic [CW-1:0]  cnt;
  logic [TW-1:0]  timer;
  logic [6:0]     ref_row;
  logic           ref_pending;
  logic [13:0]    addr;
  logic           wr;

  logic pick_vid;
  logic gnt_ref, gnt_vid, gnt_cpu;
  logic tick, ref_done;

`ifdef DRAM_SEQ_FAIR_EN
  // rr_vid = 1 means video wins the next contested IDLE.
  logic rr_vid;

  always_ff @(posedge pin_clk) begin
    if (pin_rst)      rr_vid <= 1'b1;
    else if (gnt_vid) rr_vid <= 1'b0;
    else if (gnt_cpu) rr_vid <= 1'b1;
  end

  always_comb pick_vid = vid_req && (!cpu_req || rr_vid);
`else
  always_comb pick_vid = vid_req;
`endif

  always_comb begin
    gnt_ref = 1'b0;
    gnt_vid = 1'b0;
    gnt_cpu = 1'b0;
    if (state == S_IDLE) begin
      if (ref_pending)   gnt_ref = 1'b1;
      else if (pick_vid) gnt_vid = 1'b1;
      else if (cpu_req)  gnt_cpu = 1'b1;
    end
  end

  always_comb begin
    tick     = (timer == TMR_LAST);
    ref_done = (state == S_PRE) && (cnt == RP_LAST) && (kind == K_REF);
  end

  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      state       <= S_IDLE;
      kind        <= K_REF;
      cnt         <= '0;
      timer       <= '0;
      ref_row     <= '0;
      ref_pending <= 1'b0;
      ref_miss    <= 1'b0;
      addr        <= '0;
      wr          <= 1'b0;
      ram_ma      <= '0;
      ram_di      <= '0;
      ram_ras_n   <= 1'b1;
      ram_cas_n   <= 1'b1;
      ram_we_n    <= 1'b1;
      cpu_ack     <= 1'b0;
      vid_ack     <= 1'b0;
      cpu_rdata   <= '0;
      vid_rdata   <= '0;
    end else begin
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;

      timer <= tick ? '0 : timer + 1'b1;
      // A tick coinciding with refresh completion re-arms the request and counts as a miss.
      ref_pending <= tick | (ref_pending & ~ref_done);
      if (tick && ref_pending) ref_miss <= 1'b1;

      case (state)
        S_IDLE: begin
          ram_ras_n <= 1'b1;
          ram_cas_n <= 1'b1;
          ram_we_n  <= 1'b1;
          if (gnt_ref) begin
            kind   <= K_REF;
            wr     <= 1'b0;
            ram_ma <= ref_row;
            state  <= S_ADDR;
          end else if (gnt_vid) begin
            kind   <= K_VID;
            wr     <= 1'b0;
            addr   <= vid_addr;
            ram_ma <= vid_addr[6:0];
            state  <= S_ADDR;
          end else if (gnt_cpu) begin
            kind   <= K_CPU;
            wr     <= cpu_we;
            addr   <= cpu_addr;
            ram_ma <= cpu_addr[6:0];
            ram_di <= cpu_wdata;
            state  <= S_ADDR;
          end
        end

        S_ADDR: begin
          ram_ras_n <= 1'b0;
          ram_ma    <= (kind == K_REF) ? ref_row : addr[6:0];
          cnt       <= '0;
          state     <= S_RAS;
        end

        S_RAS: begin
          ram_ma <= (kind == K_REF) ? ref_row : addr[13:7];
          if (cnt == RCD_LAST) begin
            cnt       <= '0;
            ram_cas_n <= (kind == K_REF);
            ram_we_n  <= ~wr;
            state     <= S_CAS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_CAS: begin
          if (cnt == CAS_LAST) begin
            if (kind == K_CPU && !wr) cpu_rdata <= ram_do;
            if (kind == K_VID)        vid_rdata <= ram_do;
            cpu_ack   <= (kind == K_CPU);
            vid_ack   <= (kind == K_VID);
            ram_ras_n <= 1'b1;
            ram_cas_n <= 1'b1;
            ram_we_n  <= 1'b1;
            cnt       <= '0;
            state     <= S_PRE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_PRE: begin
          if (cnt == RP_LAST) begin
            if (kind == K_REF) ref_row <= ref_row + 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
